// File: rtl/dvs_event_packetizer.sv
// DVS event packetizer: keeps a free-running microsecond timestamp, accepts
// pixel events, range-checks and stamps them, and serialises each accepted
// event into NUM_PKTS fixed-width RAVENS packets, most-significant word first.
// Optional delta mode replaces the absolute timestamp with the difference to
// the previously emitted event.
module dvs_event_packetizer #(
  parameter int DVS_WIDTH_PXLS        = 346,
  parameter int DVS_HEIGHT_PXLS       = 260,
  parameter int TIMESTAMP_US_BITS     = 48,
  parameter int CLK_PERIOD_US_DIVISOR = 1000,
  parameter int RAVENS_PKT_BITS       = 32,
  parameter int DELTA_MODE            = 0,
  localparam int X_BITS = $clog2(DVS_WIDTH_PXLS),
  localparam int Y_BITS = $clog2(DVS_HEIGHT_PXLS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         evt_valid,
  output logic                         evt_ready,
  input  logic [X_BITS-1:0]            evt_x,
  input  logic [Y_BITS-1:0]            evt_y,
  input  logic                         evt_pol,
  output logic                         pkt_valid,
  input  logic                         pkt_ready,
  output logic [RAVENS_PKT_BITS-1:0]   pkt_data,
  output logic                         pkt_last,
  output logic [TIMESTAMP_US_BITS-1:0] ts_us,
  output logic [15:0]                  drop_count
);

  localparam int EVENT_BITS = X_BITS + Y_BITS + 1 + TIMESTAMP_US_BITS;
  localparam int NUM_PKTS   = (EVENT_BITS + RAVENS_PKT_BITS - 1) / RAVENS_PKT_BITS;
  localparam int BUF_BITS   = NUM_PKTS * RAVENS_PKT_BITS;
  localparam int PS_BITS    = (CLK_PERIOD_US_DIVISOR > 1) ? $clog2(CLK_PERIOD_US_DIVISOR) : 1;
  localparam int IDX_BITS   = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;

  localparam logic [PS_BITS-1:0]  PS_MAX   = PS_BITS'(CLK_PERIOD_US_DIVISOR - 1);
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(NUM_PKTS - 1);
  // Largest legal coordinates; W-1 always fits in clog2(W) bits.
  localparam logic [X_BITS-1:0]   X_MAX    = X_BITS'(DVS_WIDTH_PXLS - 1);
  localparam logic [Y_BITS-1:0]   Y_MAX    = Y_BITS'(DVS_HEIGHT_PXLS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [PS_BITS-1:0]           r_prescale;
  logic [TIMESTAMP_US_BITS-1:0] r_ts;
  logic [TIMESTAMP_US_BITS-1:0] r_last_ts;
  logic [15:0]                  r_drop_count;
  logic [BUF_BITS-1:0]          r_buf;
  logic [IDX_BITS-1:0]          r_idx;

  logic                         w_accept;
  logic                         w_in_range;
  logic                         w_load;
  logic                         w_drop;
  logic                         w_pkt_fire;
  logic                         w_at_last;
  logic [TIMESTAMP_US_BITS-1:0] w_ts_delta;
  logic [TIMESTAMP_US_BITS-1:0] w_ts_field;
  logic [EVENT_BITS-1:0]        w_event;
  logic [BUF_BITS-1:0]          w_buf_load;
  logic [IDX_BITS-1:0]          w_word_sel;
  logic [RAVENS_PKT_BITS-1:0]   w_words [NUM_PKTS];

  assign w_accept   = evt_valid & evt_ready;
  assign w_in_range = (evt_x <= X_MAX) && (evt_y <= Y_MAX);
  assign w_load     = w_accept & w_in_range;
  assign w_drop     = w_accept & ~w_in_range;
  assign w_pkt_fire = pkt_valid & pkt_ready;
  assign w_at_last  = (r_idx == IDX_LAST);

  // The stamp is the registered timestamp of the handshake cycle, so an event
  // taken on a prescaler wrap carries the pre-increment value.
  assign w_ts_delta = r_ts - r_last_ts;
  assign w_ts_field = (DELTA_MODE != 0) ? w_ts_delta : r_ts;
  assign w_event    = {evt_x, evt_y, evt_pol, w_ts_field};
  assign w_buf_load = BUF_BITS'(w_event);

  // Packet k is word NUM_PKTS-1-k of the buffer, so the top word leaves first.
  assign w_word_sel = IDX_LAST - r_idx;

  generate
    for (genvar gi = 0; gi < NUM_PKTS; gi++) begin : g_words
      assign w_words[gi] = r_buf[gi*RAVENS_PKT_BITS +: RAVENS_PKT_BITS];
    end
  endgenerate

  assign ts_us      = r_ts;
  assign drop_count = r_drop_count;

  // Prescaler and microsecond timestamp; ts wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= '0;
      r_ts       <= '0;
    end else if (r_prescale == PS_MAX) begin
      r_prescale <= '0;
      r_ts       <= r_ts + 1'b1;
    end else begin
      r_prescale <= r_prescale + 1'b1;
    end
  end

  // Saturating count of events rejected by the range check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  // Event buffer, packet index and last-emitted timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf     <= '0;
      r_idx     <= '0;
      r_last_ts <= '0;
    end else if (w_load) begin
      r_buf     <= w_buf_load;
      r_idx     <= '0;
      r_last_ts <= r_ts;
    end else if (w_pkt_fire && !w_at_last) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a reload on the final packet keeps SEND with no bubble.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_pkt_fire && w_at_last) begin
          w_state_next = w_load ? ST_SEND : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs: data is driven straight from the buffer, so it is stable under stall.
  always_comb begin
    evt_ready = 1'b0;
    pkt_valid = 1'b0;
    pkt_last  = 1'b0;
    pkt_data  = '0;
    case (r_state)
      ST_IDLE: begin
        evt_ready = 1'b1;
      end
      ST_SEND: begin
        pkt_valid = 1'b1;
        pkt_last  = w_at_last;
        pkt_data  = w_words[w_word_sel];
        evt_ready = w_at_last & pkt_ready;
      end
      default: begin
        evt_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dvs_event_packetizer.sv
// Bench for dvs_event_packetizer: a queue-based transaction model checks the
// main instance (divisor 4) every cycle; two further instances pin the
// default packing and delta-timestamp behaviour with literal expectations.
module tb_dvs_event_packetizer;

  localparam int XB  = $clog2(346);
  localparam int YB  = $clog2(260);
  localparam int TSW = 48;
  localparam int DIV = 4;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } pkt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- main instance (divisor 4, absolute timestamps)
  logic          rst_n = 1'b1;
  logic          evt_valid = 1'b0;
  logic          evt_ready;
  logic [XB-1:0] evt_x = '0;
  logic [YB-1:0] evt_y = '0;
  logic          evt_pol = 1'b0;
  logic          pkt_valid;
  logic          pkt_ready = 1'b0;
  logic [31:0]   pkt_data;
  logic          pkt_last;
  logic [47:0]   ts_us;
  logic [15:0]   drop_count;

  dvs_event_packetizer #(.CLK_PERIOD_US_DIVISOR(DIV)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_x(evt_x), .evt_y(evt_y), .evt_pol(evt_pol),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_data(pkt_data), .pkt_last(pkt_last),
    .ts_us(ts_us), .drop_count(drop_count)
  );

  // ---------------- packing instance (all defaults)
  logic          p_rst_n = 1'b1;
  logic          p_evt_valid = 1'b0;
  logic          p_evt_ready;
  logic [XB-1:0] p_evt_x = '0;
  logic [YB-1:0] p_evt_y = '0;
  logic          p_evt_pol = 1'b0;
  logic          p_pkt_valid;
  logic          p_pkt_ready = 1'b0;
  logic [31:0]   p_pkt_data;
  logic          p_pkt_last;
  logic [47:0]   p_ts_us;
  logic [15:0]   p_drop_count;

  dvs_event_packetizer u_pack (
    .clk(clk), .rst_n(p_rst_n),
    .evt_valid(p_evt_valid), .evt_ready(p_evt_ready),
    .evt_x(p_evt_x), .evt_y(p_evt_y), .evt_pol(p_evt_pol),
    .pkt_valid(p_pkt_valid), .pkt_ready(p_pkt_ready),
    .pkt_data(p_pkt_data), .pkt_last(p_pkt_last),
    .ts_us(p_ts_us), .drop_count(p_drop_count)
  );

  // ---------------- delta instance (divisor 1, delta timestamps)
  logic          d_rst_n = 1'b1;
  logic          d_evt_valid = 1'b0;
  logic          d_evt_ready;
  logic [XB-1:0] d_evt_x = '0;
  logic [YB-1:0] d_evt_y = '0;
  logic          d_evt_pol = 1'b0;
  logic          d_pkt_valid;
  logic          d_pkt_ready = 1'b1;
  logic [31:0]   d_pkt_data;
  logic          d_pkt_last;
  logic [47:0]   d_ts_us;
  logic [15:0]   d_drop_count;

  dvs_event_packetizer #(.CLK_PERIOD_US_DIVISOR(1), .DELTA_MODE(1)) u_delta (
    .clk(clk), .rst_n(d_rst_n),
    .evt_valid(d_evt_valid), .evt_ready(d_evt_ready),
    .evt_x(d_evt_x), .evt_y(d_evt_y), .evt_pol(d_evt_pol),
    .pkt_valid(d_pkt_valid), .pkt_ready(d_pkt_ready),
    .pkt_data(d_pkt_data), .pkt_last(d_pkt_last),
    .ts_us(d_ts_us), .drop_count(d_drop_count)
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Event word built arithmetically from field positions: ts in the LSBs,
  // then pol, y, x; everything above is zero.
  function automatic logic [95:0] pack_evt(input int x, input int y, input logic pol,
                                           input logic [47:0] tsf);
    logic [95:0] w;
    w = 96'(tsf);
    w = w + (96'(pol) << TSW);
    w = w + (96'(y) << (TSW + 1));
    w = w + (96'(x) << (TSW + 1 + YB));
    return w;
  endfunction

  // ---------------- model state for the main instance
  longint      m_cyc = 0;       // rising edges seen out of reset
  int          m_drops = 0;
  pkt_t        mq[$];           // packets still owed, front is on the bus
  logic [31:0] obs[$];          // packets the DUT actually handed over
  int          acc_cnt = 0;
  bit          acc_b2b = 0;
  bit          chk_en = 0;

  logic [31:0] p_obs[$];
  logic        p_lst[$];
  logic [31:0] d_obs[$];

  // Model update and DUT observation on every rising edge (pre-edge values).
  always @(posedge clk) begin
    bit          m_rdy;
    logic [95:0] w;
    if (!rst_n) begin
      m_cyc   = 0;
      m_drops = 0;
      mq.delete();
    end else begin
      if (pkt_valid && pkt_ready) obs.push_back(pkt_data);
      if (evt_valid && evt_ready) begin
        acc_cnt++;
        acc_b2b = pkt_valid && pkt_last && pkt_ready;
        $display("[%0t] event x=%0d y=%0d pol=%0d ts=%0d %s", $time, evt_x, evt_y,
                 evt_pol, ts_us, ((evt_x < 346) && (evt_y < 260)) ? "queued" : "dropped");
      end
      m_rdy = (mq.size() == 0);
      if (mq.size() > 0) m_rdy = mq[0].l && pkt_ready;
      if (mq.size() > 0 && pkt_ready) void'(mq.pop_front());
      if (evt_valid && m_rdy) begin
        if (evt_x < 346 && evt_y < 260) begin
          w = pack_evt(int'(evt_x), int'(evt_y), evt_pol, 48'((m_cyc / DIV)));
          for (int k = 0; k < 3; k++) mq.push_back('{d: w[95-32*k -: 32], l: (k == 2)});
        end else if (m_drops < 65535) begin
          m_drops++;
        end
      end
      m_cyc++;
    end
    if (p_rst_n && p_pkt_valid && p_pkt_ready) begin
      p_obs.push_back(p_pkt_data);
      p_lst.push_back(p_pkt_last);
    end
    if (d_rst_n && d_pkt_valid && d_pkt_ready) d_obs.push_back(d_pkt_data);
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    bit exp_rdy;
    if (chk_en) begin
      if (!rst_n) begin
        chk("reset pkt_valid", 96'(pkt_valid), 96'd0);
        chk("reset pkt_last", 96'(pkt_last), 96'd0);
        chk("reset pkt_data", 96'(pkt_data), 96'd0);
        chk("reset ts_us", 96'(ts_us), 96'd0);
        chk("reset drop_count", 96'(drop_count), 96'd0);
      end else begin
        chk("ts_us", 96'(ts_us), 96'(48'(m_cyc / DIV)));
        chk("drop_count", 96'(drop_count), 96'(m_drops));
        chk("pkt_valid", 96'(pkt_valid), 96'(mq.size() > 0));
        exp_rdy = (mq.size() == 0);
        if (mq.size() > 0) begin
          exp_rdy = mq[0].l && pkt_ready;
          chk("pkt_data", 96'(pkt_data), 96'(mq[0].d));
          chk("pkt_last", 96'(pkt_last), 96'(mq[0].l));
        end
        chk("evt_ready", 96'(evt_ready), 96'(exp_rdy));
      end
    end
  end

  // Waits for the next main-instance handshake, optionally toggling pkt_ready.
  task automatic wait_acc(input string name, input bit rnd_ready);
    int start;
    int n;
    start = acc_cnt;
    n = 0;
    while (acc_cnt == start && n < 200) begin
      @(posedge clk);
      #2;
      if (rnd_ready) pkt_ready = 1'($urandom % 2);
      n++;
    end
    if (acc_cnt == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no handshake within 200 cycles", name);
    end
  endtask

  initial begin
    int ob0;
    int n;

    chk("model pack literal", pack_evt(5, 3, 1'b1, 48'd10), 96'h00000000_14070000_0000000A);
    chk("model pack delta literal", pack_evt(3, 4, 1'b1, 48'd12), 96'h00000000_0C090000_0000000C);

    // Reset the main instance; edge count restarts after release.
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("post-reset ts_us", 96'(ts_us), 96'd0);
    chk("post-reset evt_ready", 96'(evt_ready), 96'd1);
    chk("post-reset pkt_valid", 96'(pkt_valid), 96'd0);

    // Timestamp: 12 edges at divisor 4 gives 3 us.
    repeat (12) @(posedge clk);
    #1 chk("ts after 12 cycles", 96'(ts_us), 96'd3);
    #1;
    // Event taken on the prescaler wrap edge (edge 16) must carry ts=3.
    repeat (3) @(posedge clk);
    #2;
    ob0 = obs.size();
    evt_x = 9'd5; evt_y = 9'd3; evt_pol = 1'b1; pkt_ready = 1'b1; evt_valid = 1'b1;
    wait_acc("wrap event", 1'b0);
    evt_valid = 1'b0;
    chk("ts after wrap accept", 96'(ts_us), 96'd4);
    repeat (4) @(posedge clk);
    #2;
    chk("wrap event packet count", 96'(obs.size() - ob0), 96'd3);
    if (obs.size() - ob0 == 3) begin
      chk("wrap event word1", 96'(obs[ob0+1]), 96'h14070000);
      chk("wrap event word0 pre-increment ts", 96'(obs[ob0+2]), 96'h00000003);
    end

    // Range drop: two out-of-range events, no packets, drop_count=2.
    ob0 = obs.size();
    evt_x = 9'd346; evt_y = 9'd0; evt_valid = 1'b1;
    wait_acc("drop x", 1'b0);
    evt_x = 9'd0; evt_y = 9'd260;
    wait_acc("drop y", 1'b0);
    evt_valid = 1'b0;
    chk("drop_count after two drops", 96'(drop_count), 96'd2);
    repeat (3) @(posedge clk);
    #2 chk("no packets from drops", 96'(obs.size() - ob0), 96'd0);

    // Backpressure and back-to-back: two events offered continuously.
    ob0 = obs.size();
    evt_x = 9'd10; evt_y = 9'd20; evt_pol = 1'b0; evt_valid = 1'b1;
    wait_acc("b2b first", 1'b1);
    evt_x = 9'd300; evt_y = 9'd250; evt_pol = 1'b1;
    wait_acc("b2b second", 1'b1);
    chk("second accepted on last&ready", 96'(acc_b2b), 96'd1);
    evt_valid = 1'b0;
    n = 0;
    while ((obs.size() - ob0) < 6 && n < 200) begin
      @(posedge clk); #2 pkt_ready = 1'($urandom % 2);
      n++;
    end
    chk("b2b packet count", 96'(obs.size() - ob0), 96'd6);

    // Random traffic with random backpressure and occasional out-of-range events.
    repeat (400) begin
      @(posedge clk); #2;
      evt_valid = 1'($urandom % 2);
      evt_x     = 9'($urandom_range(0, 359));
      evt_y     = 9'($urandom_range(0, 269));
      evt_pol   = 1'($urandom % 2);
      pkt_ready = ($urandom % 4) != 0;
    end
    evt_valid = 1'b0; pkt_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    // Reset after the first packet of a burst.
    evt_x = 9'd7; evt_y = 9'd8; evt_pol = 1'b0; evt_valid = 1'b1;
    wait_acc("midburst event", 1'b0);
    evt_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midburst reset pkt_valid", 96'(pkt_valid), 96'd0);
    chk("midburst reset pkt_data", 96'(pkt_data), 96'd0);
    chk("midburst reset ts_us", 96'(ts_us), 96'd0);
    ob0 = obs.size();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2 chk("no packets after midburst reset", 96'(obs.size() - ob0), 96'd0);

    // Packing with default parameters: 10 us then x=5 y=3 pol=1.
    @(posedge clk); #2 p_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 p_rst_n = 1'b1;
    chk("pack reset ts_us", 96'(p_ts_us), 96'd0);
    chk("pack reset evt_ready", 96'(p_evt_ready), 96'd1);
    repeat (10000) @(posedge clk);
    #1 chk("pack ts after 10us", 96'(p_ts_us), 96'd10);
    #1;
    p_evt_x = 9'd5; p_evt_y = 9'd3; p_evt_pol = 1'b1; p_pkt_ready = 1'b1; p_evt_valid = 1'b1;
    @(posedge clk);
    #2 p_evt_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pack packet count", 96'(p_obs.size()), 96'd3);
    if (p_obs.size() == 3) begin
      chk("pack word2", 96'(p_obs[0]), 96'h00000000);
      chk("pack word1", 96'(p_obs[1]), 96'h14070000);
      chk("pack word0", 96'(p_obs[2]), 96'h0000000A);
      chk("pack last flags", 96'({p_lst[0], p_lst[1], p_lst[2]}), 96'b001);
    end

    // Delta mode at divisor 1: events at ts 7 and 19 give fields 7 and 12.
    @(posedge clk); #2 d_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 d_rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    d_evt_x = 9'd1; d_evt_y = 9'd2; d_evt_pol = 1'b0; d_evt_valid = 1'b1;
    @(posedge clk);
    #2 d_evt_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    d_evt_x = 9'd3; d_evt_y = 9'd4; d_evt_pol = 1'b1; d_evt_valid = 1'b1;
    @(posedge clk);
    #2 d_evt_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("delta packet count", 96'(d_obs.size()), 96'd6);
    if (d_obs.size() == 6) begin
      chk("delta first word1", 96'(d_obs[1]), 96'h04040000);
      chk("delta first ts_field", 96'(d_obs[2]), 96'd7);
      chk("delta second word1", 96'(d_obs[4]), 96'h0C090000);
      chk("delta second ts_field", 96'(d_obs[5]), 96'd12);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dvs_event_packetizer.md
Name: dvs_event_packetizer

Overview:
- Parametrised successor to the fixed DVS/RAVENS constant set. Width, height, timestamp width, clock divisor and packet width are all parameters.
- Generates the free-running microsecond timestamp.
- Accepts DVS pixel events, range-checks them, and stamps each with the timestamp.
- Serialises each event into a burst of fixed-width RAVENS packets. Optional delta-timestamp mode.
- Sits between the DVS event capture logic and the RAVENS packet link.

Parameters:
- DVS_WIDTH_PXLS, 346, sensor width; X_BITS = $clog2(DVS_WIDTH_PXLS)
- DVS_HEIGHT_PXLS, 260, sensor height; Y_BITS = $clog2(DVS_HEIGHT_PXLS)
- TIMESTAMP_US_BITS, 48, timestamp field width
- CLK_PERIOD_US_DIVISOR, 1000, clock cycles per microsecond (must be >= 1)
- RAVENS_PKT_BITS, 32, output packet width
- DELTA_MODE, 0, 0 = absolute timestamp; 1 = timestamp delta since previous emitted event
- Derived: EVENT_BITS = X_BITS+Y_BITS+1+TIMESTAMP_US_BITS; NUM_PKTS = ceil(EVENT_BITS/RAVENS_PKT_BITS). Defaults give 67 bits and 3 packets.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- evt_valid  in  1  event offered
- evt_ready  out  1  event accepted when valid&ready
- evt_x  in  X_BITS  pixel column
- evt_y  in  Y_BITS  pixel row
- evt_pol  in  1  polarity
- pkt_valid  out  1  packet valid
- pkt_ready  in  1  downstream accepts packet
- pkt_data  out  RAVENS_PKT_BITS  packet payload
- pkt_last  out  1  final packet of an event
- ts_us  out  TIMESTAMP_US_BITS  current microsecond timestamp
- drop_count  out  16  saturating count of out-of-range events

Behaviour:
- Reset (async assert, sync-released use): all outputs and state are cleared.
  - ts_us=0, prescaler=0, drop_count=0, state=IDLE.
  - pkt_valid=0, pkt_last=0, pkt_data=0.
  - evt_ready=1 after reset deasserts.
  - Last-emitted timestamp register=0.
- Reset mid-burst: the in-flight event is discarded and no further packets of it are emitted.
- Timestamp prescaler: counts 0..CLK_PERIOD_US_DIVISOR-1. In the cycle it equals DIVISOR-1 it wraps to 0 and ts_us increments.
  - ts_us wraps modulo 2^TIMESTAMP_US_BITS.
  - With DIVISOR=1, ts_us increments every cycle.
- Capture: on an evt_valid&evt_ready cycle, the registered ts_us value of that cycle (pre-increment) is stamped into the event.
- Range check: evt_x >= DVS_WIDTH_PXLS or evt_y >= DVS_HEIGHT_PXLS means the event is dropped.
  - The handshake still completes.
  - drop_count increments, saturating at 0xFFFF.
  - No packets are emitted and the state stays IDLE.
- Event word: {zero pad to NUM_PKTS*RAVENS_PKT_BITS, x, y, pol, ts_field}, with ts_field in the LSBs.
  - DELTA_MODE=0: ts_field = captured ts.
  - DELTA_MODE=1: ts_field = captured ts − last emitted ts, modulo 2^TIMESTAMP_US_BITS.
  - The last-emitted register updates only for events that pass the range check.
  - The first event after reset is therefore relative to 0.
- States:
  - IDLE: evt_ready=1, pkt_valid=0. A valid in-range handshake loads the shift buffer, sets pkt_idx=0 and moves to SEND.
  - SEND: pkt_valid=1 and pkt_data = word NUM_PKTS-1-pkt_idx, most-significant word first. pkt_last=1 when pkt_idx=NUM_PKTS-1.
    - On pkt_ready, pkt_idx increments.
    - On the last packet with pkt_ready, go to IDLE.
    - Back-to-back: evt_ready is also 1 in SEND when pkt_last&pkt_ready. A valid in-range event that cycle reloads the buffer and stays in SEND, pkt_idx=0, with no bubble. A simultaneous out-of-range event drops and goes to IDLE.
- Output stability: pkt_data and pkt_last are held stable while pkt_valid&!pkt_ready.
- Latency: the first packet is valid the cycle after the event handshake, giving a minimum of NUM_PKTS cycles per event.
- Single-entry buffering: there is no FIFO, and upstream backpressure is via evt_ready.

Test Plan:
- Packing (defaults, DIVISOR=1000): reset, hold 10 µs, send x=5 y=3 pol=1.
  - Expect packets 0x00000000, 0x14070000, 0x0000000A.
  - pkt_last is asserted on the third packet only.
- Timestamp (DIVISOR=4): ts_us increments exactly every 4 cycles from reset. An event accepted on the cycle the prescaler wraps carries the pre-increment value.
- Range drop: send x=346 y=0, then x=0 y=260.
  - No pkt_valid at any point.
  - drop_count=2.
  - evt_ready never deasserts.
- Backpressure and back-to-back: randomly toggle pkt_ready while offering two events continuously.
  - Data is held stable while stalled.
  - 6 packets are emitted in order.
  - The second event is accepted on the cycle of the first event's pkt_last&pkt_ready.
- DELTA_MODE=1 (DIVISOR=1): events accepted at ts 7 and 19 produce ts_field 7 then 12.
- Async reset asserted after the first packet of a burst: outputs are cleared immediately and no remaining packets appear after release.
